// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared constants, state encoding and PC checks for the fetch unit
package ifetch_unit_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_ISSUE = 2'd0,
      IF_WAIT  = 2'd1,
      IF_VALID = 2'd2
   } if_state_t;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

   function automatic logic pc_out_of_range(input logic [31:0] pc, input logic [31:0] limit);
      return pc >= limit;
   endfunction

endpackage

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch: PC, imem request, capture and valid/ready handoff
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 131072
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   output logic        imem_stall,
   input  logic [31:0] imem_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_misalign,
   output logic        instr_fault,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   if_state_t   state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] instr_next, instr_pc_next;
   logic        misalign_q, misalign_next;
   logic        fault_q, fault_next;
   logic [31:0] npc;
   logic        pc_bad, npc_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IF_ISSUE;
         pc         <= RESET_PC;
         instr      <= NOP_INSTR;
         instr_pc   <= RESET_PC;
         misalign_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         instr      <= instr_next;
         instr_pc   <= instr_pc_next;
         misalign_q <= misalign_next;
         fault_q    <= fault_next;
      end
   end

   // Next fetch target when the held instruction is accepted; pc+4 wraps at 2^32.
   assign npc     = redirect_valid ? redirect_pc : pc + 32'd4;
   assign pc_bad  = pc_misaligned(pc)  || pc_out_of_range(pc, MEM_LIMIT);
   assign npc_bad = pc_misaligned(npc) || pc_out_of_range(npc, MEM_LIMIT);

   always_comb begin
      state_next    = state;
      pc_next       = pc;
      instr_next    = instr;
      instr_pc_next = instr_pc;
      misalign_next = misalign_q;
      fault_next    = fault_q;
      imem_addr     = pc;
      imem_stall    = 1'b1;

      case (state)
         IF_ISSUE: begin
            // Bad PCs and pending redirects never reach memory.
            imem_stall = !fetch_en || pc_bad || redirect_valid;
            if (redirect_valid) begin
               pc_next = redirect_pc;
            end else if (fetch_en) begin
               if (pc_bad) begin
                  state_next    = IF_VALID;
                  instr_next    = NOP_INSTR;
                  instr_pc_next = pc;
                  misalign_next = pc_misaligned(pc);
                  fault_next    = pc_out_of_range(pc, MEM_LIMIT);
               end else begin
                  state_next = IF_WAIT;
               end
            end
         end

         IF_WAIT: begin
            if (redirect_valid) begin
               pc_next    = redirect_pc;
               state_next = IF_ISSUE;
            end else begin
               instr_next    = imem_data;
               instr_pc_next = pc;
               misalign_next = 1'b0;
               fault_next    = 1'b0;
               state_next    = IF_VALID;
            end
         end

         IF_VALID: begin
            if (instr_ready) begin
               pc_next = npc;
               // Overlap the next request with the accept cycle when it is safe to.
               if (fetch_en && !npc_bad) begin
                  imem_addr  = npc;
                  imem_stall = 1'b0;
                  state_next = IF_WAIT;
               end else begin
                  state_next = IF_ISSUE;
               end
            end else if (redirect_valid) begin
               pc_next    = redirect_pc;
               state_next = IF_ISSUE;
            end
         end

         default: state_next = IF_ISSUE;
      endcase

      if (rst) begin
         imem_addr  = RESET_PC;
         imem_stall = 1'b0;
      end
   end

   assign instr_valid    = (state == IF_VALID);
   assign instr_misalign = misalign_q && instr_valid;
   assign instr_fault    = fault_q && instr_valid;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed bench for ifetch_unit with a one-cycle imem model
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic        imem_stall;
   logic [31:0] imem_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_misalign;
   logic        instr_fault;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   ifetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_stall     (imem_stall),
      .imem_data      (imem_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_misalign (instr_misalign),
      .instr_fault    (instr_fault),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // imem model: word[i] = 0x1000_0000 + i, address latched when not stalled
   logic [31:0] imem_lat = 32'h0;
   always @(posedge clk) if (!imem_stall) imem_lat <= imem_addr;
   assign imem_data = 32'h1000_0000 + {2'b00, imem_lat[31:2]};

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_valid_instr(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc);
      chk({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, " instr"}, instr, e_instr);
      chk({tag, " pc"}, instr_pc, e_pc);
   endtask

   initial begin
      rst = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;

      // 1. reset and streaming fetch
      step();
      chk("rst stall", {31'd0, imem_stall}, 32'd0);
      chk("rst addr", imem_addr, 32'h0);
      step();
      chk("rst valid", {31'd0, instr_valid}, 32'd0);
      chk("rst instr", instr, NOP);
      chk("rst instr_pc", instr_pc, 32'h0);
      chk("rst flags", {30'd0, instr_misalign, instr_fault}, 32'd0);
      rst = 1'b0;
      #1;
      chk("issue0 stall", {31'd0, imem_stall}, 32'd0);
      chk("issue0 addr", imem_addr, 32'h0);
      step();
      chk("wait0 valid", {31'd0, instr_valid}, 32'd0);
      chk("wait0 stall", {31'd0, imem_stall}, 32'd1);
      step();
      chk_valid_instr("fetch0", 32'h1000_0000, 32'h0);
      chk("overlap addr", imem_addr, 32'h4);
      chk("overlap stall", {31'd0, imem_stall}, 32'd0);
      step(); chk("gap valid", {31'd0, instr_valid}, 32'd0);
      step(); chk_valid_instr("fetch1", 32'h1000_0001, 32'h4);
      step(); step(); chk_valid_instr("fetch2", 32'h1000_0002, 32'h8);
      step(); step(); chk_valid_instr("fetch3", 32'h1000_0003, 32'hC);

      // 2. backpressure in VALID
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_valid_instr("hold", 32'h1000_0003, 32'hC);
         chk("hold stall", {31'd0, imem_stall}, 32'd1);
      end
      instr_ready = 1'b1;
      #1;
      chk("accept addr", imem_addr, 32'h10);
      step(); step();
      chk_valid_instr("fetch4", 32'h1000_0004, 32'h10);

      // 3. redirect during WAIT discards the in-flight word
      step();
      chk("wait5 valid", {31'd0, instr_valid}, 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      #1;
      chk("redir issue valid", {31'd0, instr_valid}, 32'd0);
      chk("redir issue addr", imem_addr, 32'h40);
      step();
      chk("redir wait valid", {31'd0, instr_valid}, 32'd0);
      step();
      chk_valid_instr("redir fetch", 32'h1000_0010, 32'h40);

      // 4. misaligned and out-of-range targets
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      #1;
      chk("bad npc stall", {31'd0, imem_stall}, 32'd1);
      step();
      redirect_valid = 1'b0; instr_ready = 1'b0;
      #1;
      chk("misal issue stall", {31'd0, imem_stall}, 32'd1);
      step();
      chk_valid_instr("misal", NOP, 32'h42);
      chk("misal flag", {31'd0, instr_misalign}, 32'd1);
      chk("misal fault", {31'd0, instr_fault}, 32'd0);
      chk("misal stall", {31'd0, imem_stall}, 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h2_0000;
      step();
      redirect_valid = 1'b0;
      #1;
      chk("drop valid", {31'd0, instr_valid}, 32'd0);
      chk("drop flags", {30'd0, instr_misalign, instr_fault}, 32'd0);
      step();
      chk_valid_instr("fault", NOP, 32'h2_0000);
      chk("fault flags", {30'd0, instr_misalign, instr_fault}, 32'd1);

      // 5. fetch_en low parks in ISSUE
      fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("park valid", {31'd0, instr_valid}, 32'd0);
         chk("park stall", {31'd0, imem_stall}, 32'd1);
         step();
         chk("park latched", imem_lat, 32'h40);
      end
      fetch_en = 1'b1; instr_ready = 1'b1;
      #1;
      chk("resume stall", {31'd0, imem_stall}, 32'd0);
      chk("resume addr", imem_addr, 32'h80);
      step(); step();
      chk_valid_instr("resume", 32'h1000_0020, 32'h80);

      // 6. reset in WAIT and in VALID
      step();
      rst = 1'b1;
      #1;
      chk("rst wait stall", {31'd0, imem_stall}, 32'd0);
      chk("rst wait addr", imem_addr, 32'h0);
      step();
      chk("rst wait valid", {31'd0, instr_valid}, 32'd0);
      chk("rst wait ipc", instr_pc, 32'h0);
      rst = 1'b0;
      step(); step();
      chk_valid_instr("post rst", 32'h1000_0000, 32'h0);
      rst = 1'b1;
      step();
      chk("rst valid valid", {31'd0, instr_valid}, 32'd0);
      chk("rst valid instr", instr, NOP);
      rst = 1'b0; instr_ready = 1'b0;
      step(); step();
      chk_valid_instr("post rst2", 32'h1000_0000, 32'h0);

      // PC wrap: 0xFFFFFFFC faults, accept wraps next fetch to 0
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      step();
      chk_valid_instr("top fault", NOP, 32'hFFFF_FFFC);
      chk("top flags", {30'd0, instr_misalign, instr_fault}, 32'd1);
      instr_ready = 1'b1;
      #1;
      chk("wrap addr", imem_addr, 32'h0);
      chk("wrap stall", {31'd0, imem_stall}, 32'd0);
      step(); step();
      chk_valid_instr("wrap fetch", 32'h1000_0000, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
